// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches {opcode,value} at pc, then strobes it into the PC block.
// Latency: 2 cycles per instruction, plus one cycle per memReady=0 cycle in FETCH.
// Backpressure: memReq/memAddr hold until memReady; HALT waits for run; FAULT holds until reset.
module fetch_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int PC_WIDTH     = 8,
    parameter int STACK_DEPTH  = 16,
    parameter logic [OPCODE_WIDTH-1:0] RST_CODE  = 4'hF,
    parameter logic [OPCODE_WIDTH-1:0] RET_CODE  = 4'h1,
    parameter logic [OPCODE_WIDTH-1:0] CALL_CODE = 4'h2,
    parameter logic [OPCODE_WIDTH-1:0] HALT_CODE = 4'hE
) (
    input  logic                                clock,
    input  logic                                resetN,
    input  logic                                run,
    input  logic [PC_WIDTH-1:0]                 pc,
    output logic                                memReq,
    output logic [PC_WIDTH-1:0]                 memAddr,
    input  logic                                memReady,
    input  logic [OPCODE_WIDTH+VALUE_WIDTH-1:0] memData,
    output logic                                pcStep,
    output logic [OPCODE_WIDTH-1:0]             pcCode,
    output logic [VALUE_WIDTH-1:0]              pcValue,
    output logic [$clog2(STACK_DEPTH):0]        depth,
    output logic                                halted,
    output logic                                fault
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_EXECUTE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t                  state;
    logic [DW-1:0]           depth_q;
    logic [OPCODE_WIDTH-1:0] ir_op;
    logic [VALUE_WIDTH-1:0]  ir_val;

    logic is_call;
    logic is_ret;
    logic stack_err;

    assign is_call   = (ir_op == CALL_CODE);
    assign is_ret    = (ir_op == RET_CODE);
    // Over/underflow kills the step entirely so the PC never sees a bad call/return.
    assign stack_err = (is_call && (depth_q == DEPTH_MAX)) || (is_ret && (depth_q == '0));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= S_RESET;
            depth_q <= '0;
            ir_op   <= '0;
            ir_val  <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (memReady) begin
                        ir_op  <= memData[OPCODE_WIDTH+VALUE_WIDTH-1:VALUE_WIDTH];
                        ir_val <= memData[VALUE_WIDTH-1:0];
                        state  <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (stack_err) begin
                        state <= S_FAULT;
                    end else begin
                        if (is_call) depth_q <= depth_q + DEPTH_ONE;
                        if (is_ret)  depth_q <= depth_q - DEPTH_ONE;
                        state <= (ir_op == HALT_CODE) ? S_HALT : S_FETCH;
                    end
                end
                S_HALT:  if (run) state <= S_FETCH;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    // Outputs decode straight from state; gating on resetN zeroes them the instant reset asserts
    // and presents the RESET strobe as soon as it releases.
    always_comb begin
        memReq  = 1'b0;
        memAddr = '0;
        pcStep  = 1'b0;
        pcCode  = '0;
        pcValue = '0;
        halted  = 1'b0;
        fault   = 1'b0;
        if (resetN) begin
            case (state)
                S_RESET: begin
                    pcStep = 1'b1;
                    pcCode = RST_CODE;
                end
                S_FETCH: begin
                    memReq  = 1'b1;
                    memAddr = pc;
                end
                S_EXECUTE: begin
                    if (!stack_err) begin
                        pcStep  = 1'b1;
                        pcCode  = ir_op;
                        pcValue = ir_val;
                    end
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

    assign depth = depth_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC and program memory, expected pcStep strobes
// queued by the stimulus and popped by an independent monitor.
module tb_fetch_sequencer;
    localparam int OW = 4;
    localparam int VW = 8;
    localparam int PW = 8;
    localparam int DW = 5;

    logic          clock  = 1'b0;
    logic          resetN = 1'b0;
    logic          run    = 1'b0;
    logic [PW-1:0] pc     = 8'h55;
    logic          memReq;
    logic [PW-1:0] memAddr;
    logic          memReady;
    logic [OW+VW-1:0] memData;
    logic          pcStep;
    logic [OW-1:0] pcCode;
    logic [VW-1:0] pcValue;
    logic [DW-1:0] depth;
    logic          halted;
    logic          fault;

    logic [OW+VW-1:0] mem [256];
    logic [PW-1:0]    stall_addr = 8'h01;
    logic [OW+VW-1:0] exp_q [$];
    logic [OW+VW-1:0] mon_e;
    int vectors     = 0;
    int miscompares = 0;

    fetch_sequencer dut (
        .clock   (clock),
        .resetN  (resetN),
        .run     (run),
        .pc      (pc),
        .memReq  (memReq),
        .memAddr (memAddr),
        .memReady(memReady),
        .memData (memData),
        .pcStep  (pcStep),
        .pcCode  (pcCode),
        .pcValue (pcValue),
        .depth   (depth),
        .halted  (halted),
        .fault   (fault)
    );

    always #5 clock = ~clock;

    assign memData  = mem[memAddr];
    assign memReady = (memAddr != stall_addr);

    // Program counter block: reset code zeroes it, any other step advances by one.
    always @(posedge clock) begin
        if (pcStep) pc <= (pcCode == 4'hF) ? 8'h00 : pc + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (resetN && pcStep) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_step: got code %0h value %0h, want no step at %0t",
                         pcCode, pcValue, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("step", 32'({pcCode, pcValue}), 32'(mon_e));
            end
        end
    end

    task automatic wait_fetch(input logic [PW-1:0] a, input string name);
        int n = 0;
        @(negedge clock);
        while (!(memReq && memAddr == a) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(memReq && memAddr == a), 32'd1);
    endtask

    task automatic wait_fault(input string name);
        int n = 0;
        @(negedge clock);
        while (!fault && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(fault), 32'd1);
    endtask

    task automatic idle_check(input string name, input logic h, input logic f, input logic [DW-1:0] d);
        check({name, "_memReq"}, 32'(memReq), 32'd0);
        check({name, "_pcStep"}, 32'(pcStep), 32'd0);
        check({name, "_pcCodeValue"}, 32'({pcCode, pcValue}), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'(h));
        check({name, "_fault"}, 32'(fault), 32'(f));
        check({name, "_depth"}, 32'(depth), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'h300;
        mem[0] = 12'h3A5; mem[1] = 12'h43C; mem[2] = 12'h221; mem[3] = 12'h231;
        mem[4] = 12'h140; mem[5] = 12'hE77; mem[6] = 12'h511; mem[7] = 12'h207;
        mem[8] = 12'h208; mem[9] = 12'h622;

        // Reset state, then release between a rising and a falling edge.
        #2;
        idle_check("reset", 1'b0, 1'b0, 5'd0);
        check("reset_memAddr", 32'(memAddr), 32'd0);
        exp_q.push_back(12'hF00); exp_q.push_back(12'h3A5); exp_q.push_back(12'h43C);
        exp_q.push_back(12'h221); exp_q.push_back(12'h231); exp_q.push_back(12'h140);
        exp_q.push_back(12'hE77); exp_q.push_back(12'h511); exp_q.push_back(12'h207);
        exp_q.push_back(12'h208);
        #5 resetN = 1'b1;
        #1;
        check("release_pcStep", 32'(pcStep), 32'd1);
        check("release_pcCode", 32'(pcCode), 32'hF);
        @(negedge clock);
        @(negedge clock);
        check("cycle2_memReq", 32'(memReq), 32'd1);
        check("cycle2_memAddr", 32'(memAddr), 32'd0);

        // Fetch of address 1 stalled three cycles.
        wait_fetch(8'h01, "stall_found");
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("stall_memReq", 32'(memReq), 32'd1);
            check("stall_memAddr", 32'(memAddr), 32'd1);
        end
        @(posedge clock); #1 stall_addr = 8'h09;
        @(negedge clock);
        check("stall_last_memAddr", 32'(memAddr), 32'd1);
        @(negedge clock);
        check("after_stall_pcStep", 32'(pcStep), 32'd1);

        // HALT at pc=5, with run held across the executing cycle.
        wait_fetch(8'h05, "fetch5_found");
        @(posedge clock); #1 run = 1'b1;
        @(posedge clock); #1 run = 1'b0;
        @(negedge clock);
        idle_check("halt", 1'b1, 1'b0, 5'd1);
        @(negedge clock);
        idle_check("halt_hold", 1'b1, 1'b0, 5'd1);
        @(posedge clock); #1 run = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("resume_memReq", 32'(memReq), 32'd1);
        check("resume_memAddr", 32'(memAddr), 32'd6);
        check("resume_halted", 32'(halted), 32'd0);
        @(posedge clock); #1 run = 1'b0;

        // Reset dropped while waiting on memory at depth 3.
        wait_fetch(8'h09, "fetch9_found");
        check("depth_before_reset", 32'(depth), 32'd3);
        #2 resetN = 1'b0;
        #1;
        idle_check("midwait_reset", 1'b0, 1'b0, 5'd0);
        check("midwait_memAddr", 32'(memAddr), 32'd0);
        check("seg1_drained", 32'(exp_q.size()), 32'd0);

        // Return at depth 0.
        mem[0] = 12'h100;
        stall_addr = 8'hFF;
        exp_q.push_back(12'hF00);
        @(posedge clock); #2 resetN = 1'b1;
        #1;
        check("seg2_release_pcStep", 32'(pcStep), 32'd1);
        check("seg2_release_pcCode", 32'(pcCode), 32'hF);
        wait_fault("ret_underflow_fault");
        idle_check("underflow", 1'b0, 1'b1, 5'd0);
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle_check("underflow_hold", 1'b0, 1'b1, 5'd0);
        end
        run = 1'b0;
        check("seg2_drained", 32'(exp_q.size()), 32'd0);

        // Sixteen nested calls fill the stack; the seventeenth faults.
        @(posedge clock); #1 resetN = 1'b0;
        exp_q.push_back(12'hF00);
        for (int i = 0; i < 16; i++) begin
            mem[i] = {4'h2, 8'(i)};
            exp_q.push_back({4'h2, 8'(i)});
        end
        mem[16] = 12'h2FF;
        @(posedge clock); #2 resetN = 1'b1;
        wait_fetch(8'h10, "fetch16_found");
        check("depth_full", 32'(depth), 32'd16);
        wait_fault("call_overflow_fault");
        idle_check("overflow", 1'b0, 1'b1, 5'd16);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            idle_check("overflow_hold", 1'b0, 1'b1, 5'd16);
        end
        check("seg3_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be: OPCODE_WIDTH, default 4, opcode field width.
REQ-002 VALUE_WIDTH, default 8, immediate field width.
REQ-003 PC_WIDTH, default 8, program counter width.
REQ-004 STACK_DEPTH, default 16, return-stack capacity.
REQ-005 RST_CODE, default 4'hF, code that zeroes the PC.
REQ-006 RET_CODE 4'h1, CALL_CODE 4'h2, HALT_CODE 4'hE, opcode encodings.
REQ-007 Ports SHALL be as follows: one clock; reset is asynchronous and active-low. clock  in  1  rising-edge clock.
REQ-008 resetN  in  1  asynchronous active-low reset.
REQ-009 run  in  1  resume pulse, sampled only in HALT.
REQ-010 pc  in  PC_WIDTH  current PC from the program counter block.
REQ-011 memReq  out  1  program-memory read request.
REQ-012 memAddr  out  PC_WIDTH  read address.
REQ-013 memReady  in  1  memory data valid.
REQ-014 memData  in  OPCODE_WIDTH+VALUE_WIDTH  {opcode, value}.
REQ-015 pcStep  out  1  PC update enable, one-cycle strobe.
REQ-016 pcCode  out  OPCODE_WIDTH  code driven to the PC resetCode input.
REQ-017 pcValue  out  VALUE_WIDTH  driven to the PC instructionValue input.
REQ-018 depth  out  $clog2(STACK_DEPTH)+1  current call depth.
REQ-019 halted  out  1  high in HALT; fault  out  1  high in FAULT.

Function
REQ-020 States SHALL be RESET, FETCH, EXECUTE, HALT and FAULT; the PC SHALL update only on edges where pcStep=1.
REQ-021 RESET: pcStep=1, pcCode=RST_CODE for exactly one cycle; next state FETCH.
REQ-022 FETCH: memReq=1 and memAddr=pc; memReq and memAddr SHALL hold steady until memReady=1.
REQ-023 On a FETCH cycle with memReady=1, memData SHALL be latched into the instruction register; next state EXECUTE.
REQ-024 EXECUTE: pcStep=1, pcCode=latched opcode and pcValue=latched value for one cycle; memReq=0; next state FETCH.
REQ-025 Minimum throughput SHALL be 2 cycles per instruction; each extra cycle with memReady=0 SHALL add one cycle.
REQ-026 A CALL_CODE in EXECUTE SHALL increment depth; a RET_CODE SHALL decrement it; all other codes SHALL leave it unchanged.
REQ-027 A CALL_CODE with depth==STACK_DEPTH, or a RET_CODE with depth==0, SHALL suppress pcStep, leave depth unchanged and enter FAULT.
REQ-028 FAULT SHALL be absorbing until reset: fault=1, memReq=0, pcStep=0.
REQ-029 A HALT_CODE in EXECUTE SHALL issue pcStep, so the PC advances by one, and enter HALT.
REQ-030 HALT: halted=1, memReq=0, pcStep=0; run=1 SHALL go to FETCH on the next edge.
REQ-031 run SHALL be ignored in every state other than HALT, including the cycle that executes HALT_CODE.
REQ-032 memReady SHALL be ignored outside FETCH.
REQ-033 pcCode and pcValue SHALL be 0 whenever pcStep=0, except in RESET.

Reset
REQ-034 resetN=0 SHALL immediately force state RESET, depth=0, the instruction register to 0, and memReq, pcStep, halted and fault to 0, from any state including mid-FETCH wait.
REQ-035 The first rising edge after resetN rises SHALL occur with the RESET outputs of REQ-021 applied.

Verification
REQ-036 Release reset, memReady=1: cycle 1 pcStep=1 and pcCode=F; cycle 2 memReq=1 and memAddr=0.
REQ-037 FETCH with memReady low for 3 cycles: memReq=1 and memAddr constant for 4 cycles; pcStep=1 the cycle after memReady rises.
REQ-038 16 nested CALL_CODE executions: depth=16; a 17th CALL gives fault=1, pcStep=0, and memReq stays 0 afterwards.
REQ-039 RET_CODE at depth 0: fault=1, depth stays 0, no pcStep.
REQ-040 HALT_CODE at pc=5: pcStep=1, then halted=1 with no memReq; a run pulse gives FETCH with memAddr=6; run asserted during FETCH has no effect.
REQ-041 resetN dropped mid-wait at depth 3: all outputs 0 and depth 0 in the same cycle; the normal RESET sequence follows release.
